// File: rtl/pixel_coord_gen.sv
// pixel_coord_gen
//   Raster-scan coordinate generator. It walks a beam counter over an
//   H_TOTAL x V_TOTAL raster. For every active pixel it produces two
//   rotated/translated coordinate pairs for the downstream length/facet
//   CORDIC stage. The (cos_a, sin_a) rotation step and the two origins are
//   written into shadow registers with param_wr. They are latched into the
//   live registers only at the frame boundary, so a frame never changes
//   parameters partway through.
//
//   Ports
//     clk                  rising-edge clock
//     reset                synchronous, active-high reset
//     ce                   pixel enable, one pixel per cycle while high
//     cos_a, sin_a         signed per-pixel rotation step (shadowed)
//     org_x, org_y         signed pixel (0,0) position, pair 1 (shadowed)
//     org2_x, org2_y       signed pixel (0,0) position, pair 2 (shadowed)
//     param_wr             capture strobe for the shadowed inputs
//     xout, yout           pair-1 coordinate of the current output pixel
//     x2out, y2out         pair-2 coordinate of the current output pixel
//     valid                output belongs to an active pixel
//     hcount, vcount       beam position of the current output
//     line_start           first active pixel of a line
//     frame_start          first active pixel of a frame
//
//   Configuration macro
//     PIXEL_COORD_SAT_EN   defined: accumulator adds saturate to 16 bits
//                          undefined: accumulator adds wrap modulo 2^16
module pixel_coord_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic signed [15:0] cos_a,
    input  logic signed [15:0] sin_a,
    input  logic signed [15:0] org_x,
    input  logic signed [15:0] org_y,
    input  logic signed [15:0] org2_x,
    input  logic signed [15:0] org2_y,
    input  logic               param_wr,
    output logic signed [15:0] xout,
    output logic signed [15:0] yout,
    output logic signed [15:0] x2out,
    output logic signed [15:0] y2out,
    output logic               valid,
    output logic [9:0]         hcount,
    output logic [9:0]         vcount,
    output logic               line_start,
    output logic               frame_start
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

`ifdef PIXEL_COORD_SAT_EN
    // Saturating add: overflow shows as disagreement of the two top sum bits.
    function automatic logic signed [15:0] acc_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
        else                return s[15:0];
    endfunction

    // Saturating subtract, so -(-32768) never has to be formed on its own.
    function automatic logic signed [15:0] acc_sub(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] s;
        s = {a[15], a} - {b[15], b};
        if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
        else                return s[15:0];
    endfunction
`else
    // Wrapping add modulo 2^16.
    function automatic logic signed [15:0] acc_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        return a + b;
    endfunction

    // Wrapping subtract modulo 2^16.
    function automatic logic signed [15:0] acc_sub(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        return a - b;
    endfunction
`endif

    logic [9:0]         h_q, h_d, v_q, v_d;
    logic signed [15:0] sh_cos_q, sh_cos_d, sh_sin_q, sh_sin_d;
    logic signed [15:0] sh_ox_q, sh_ox_d, sh_oy_q, sh_oy_d;
    logic signed [15:0] sh_o2x_q, sh_o2x_d, sh_o2y_q, sh_o2y_d;
    logic signed [15:0] lv_cos_q, lv_cos_d, lv_sin_q, lv_sin_d;
    logic signed [15:0] rx1_q, rx1_d, ry1_q, ry1_d, rx2_q, rx2_d, ry2_q, ry2_d;
    logic signed [15:0] px1_q, px1_d, py1_q, py1_d, px2_q, px2_d, py2_q, py2_d;
    logic signed [15:0] xout_q, xout_d, yout_q, yout_d;
    logic signed [15:0] x2out_q, x2out_d, y2out_q, y2out_d;
    logic               valid_q, valid_d, ls_q, ls_d, fs_q, fs_d;
    logic [9:0]         hc_q, hc_d, vc_q, vc_d;

    logic               boundary_s, last_h_s, active_s;
    logic signed [15:0] cos_s, sin_s;
    logic signed [15:0] cx1_s, cy1_s, cx2_s, cy2_s;
    logic signed [15:0] crx1_s, cry1_s, crx2_s, cry2_s;

    // Beam decode, plus the values seen by this pixel. On the frame boundary
    // the shadow (or a same-cycle write) replaces live step and accumulators.
    always_comb begin
        boundary_s = (h_q == 10'd0) && (v_q == 10'd0);
        last_h_s   = (h_q == H_LAST);
        active_s   = (h_q < H_ACT) && (v_q < V_ACT);
        sh_cos_d   = param_wr ? cos_a  : sh_cos_q;
        sh_sin_d   = param_wr ? sin_a  : sh_sin_q;
        sh_ox_d    = param_wr ? org_x  : sh_ox_q;
        sh_oy_d    = param_wr ? org_y  : sh_oy_q;
        sh_o2x_d   = param_wr ? org2_x : sh_o2x_q;
        sh_o2y_d   = param_wr ? org2_y : sh_o2y_q;
        if (boundary_s) begin
            cos_s  = sh_cos_d;
            sin_s  = sh_sin_d;
            cx1_s  = sh_ox_d;
            cy1_s  = sh_oy_d;
            cx2_s  = sh_o2x_d;
            cy2_s  = sh_o2y_d;
            crx1_s = sh_ox_d;
            cry1_s = sh_oy_d;
            crx2_s = sh_o2x_d;
            cry2_s = sh_o2y_d;
        end else begin
            cos_s  = lv_cos_q;
            sin_s  = lv_sin_q;
            cx1_s  = px1_q;
            cy1_s  = py1_q;
            cx2_s  = px2_q;
            cy2_s  = py2_q;
            crx1_s = rx1_q;
            cry1_s = ry1_q;
            crx2_s = rx2_q;
            cry2_s = ry2_q;
        end
    end

    // Next-state: counters, live registers, accumulators and outputs.
    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        lv_cos_d = lv_cos_q;
        lv_sin_d = lv_sin_q;
        rx1_d    = rx1_q;
        ry1_d    = ry1_q;
        rx2_d    = rx2_q;
        ry2_d    = ry2_q;
        px1_d    = px1_q;
        py1_d    = py1_q;
        px2_d    = px2_q;
        py2_d    = py2_q;
        xout_d   = xout_q;
        yout_d   = yout_q;
        x2out_d  = x2out_q;
        y2out_d  = y2out_q;
        hc_d     = hc_q;
        vc_d     = vc_q;
        valid_d  = 1'b0;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (ce) begin
            lv_cos_d = cos_s;
            lv_sin_d = sin_s;
            hc_d     = h_q;
            vc_d     = v_q;
            valid_d  = active_s;
            ls_d     = active_s && (h_q == 10'd0);
            fs_d     = active_s && boundary_s;
            if (active_s) begin
                // Output carries the value before this pixel's step.
                xout_d  = cx1_s;
                yout_d  = cy1_s;
                x2out_d = cx2_s;
                y2out_d = cy2_s;
            end else begin
                xout_d  = xout_q;
            end
            rx1_d = crx1_s;
            ry1_d = cry1_s;
            rx2_d = crx2_s;
            ry2_d = cry2_s;
            if (last_h_s) begin
                // Row step is the step vector rotated by 90 degrees.
                rx1_d = acc_sub(crx1_s, sin_s);
                ry1_d = acc_add(cry1_s, cos_s);
                rx2_d = acc_sub(crx2_s, sin_s);
                ry2_d = acc_add(cry2_s, cos_s);
                px1_d = rx1_d;
                py1_d = ry1_d;
                px2_d = rx2_d;
                py2_d = ry2_d;
                h_d   = 10'd0;
                v_d   = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else if (active_s) begin
                px1_d = acc_add(cx1_s, cos_s);
                py1_d = acc_add(cy1_s, sin_s);
                px2_d = acc_add(cx2_s, cos_s);
                py2_d = acc_add(cy2_s, sin_s);
                h_d   = h_q + 10'd1;
            end else begin
                px1_d = cx1_s;
                py1_d = cy1_s;
                px2_d = cx2_s;
                py2_d = cy2_s;
                h_d   = h_q + 10'd1;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            sh_cos_q <= 16'sd0;
            sh_sin_q <= 16'sd0;
            sh_ox_q  <= 16'sd0;
            sh_oy_q  <= 16'sd0;
            sh_o2x_q <= 16'sd0;
            sh_o2y_q <= 16'sd0;
            lv_cos_q <= 16'sd0;
            lv_sin_q <= 16'sd0;
            rx1_q    <= 16'sd0;
            ry1_q    <= 16'sd0;
            rx2_q    <= 16'sd0;
            ry2_q    <= 16'sd0;
            px1_q    <= 16'sd0;
            py1_q    <= 16'sd0;
            px2_q    <= 16'sd0;
            py2_q    <= 16'sd0;
            xout_q   <= 16'sd0;
            yout_q   <= 16'sd0;
            x2out_q  <= 16'sd0;
            y2out_q  <= 16'sd0;
            hc_q     <= 10'd0;
            vc_q     <= 10'd0;
            valid_q  <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            sh_cos_q <= sh_cos_d;
            sh_sin_q <= sh_sin_d;
            sh_ox_q  <= sh_ox_d;
            sh_oy_q  <= sh_oy_d;
            sh_o2x_q <= sh_o2x_d;
            sh_o2y_q <= sh_o2y_d;
            lv_cos_q <= lv_cos_d;
            lv_sin_q <= lv_sin_d;
            rx1_q    <= rx1_d;
            ry1_q    <= ry1_d;
            rx2_q    <= rx2_d;
            ry2_q    <= ry2_d;
            px1_q    <= px1_d;
            py1_q    <= py1_d;
            px2_q    <= px2_d;
            py2_q    <= py2_d;
            xout_q   <= xout_d;
            yout_q   <= yout_d;
            x2out_q  <= x2out_d;
            y2out_q  <= y2out_d;
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            valid_q  <= valid_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign xout        = xout_q;
    assign yout        = yout_q;
    assign x2out       = x2out_q;
    assign y2out       = y2out_q;
    assign valid       = valid_q;
    assign hcount      = hc_q;
    assign vcount      = vc_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_pixel_coord_gen.sv
module tb_pixel_coord_gen;

    localparam int HA = 8;
    localparam int HT = 12;
    localparam int VA = 110;
    localparam int VT = 120;

    logic clk = 1'b0;
    logic reset = 1'b1, ce = 1'b0, param_wr = 1'b0;
    logic signed [15:0] cos_a = 16'sd0, sin_a = 16'sd0;
    logic signed [15:0] org_x = 16'sd0, org_y = 16'sd0, org2_x = 16'sd0, org2_y = 16'sd0;
    logic signed [15:0] xout, yout, x2out, y2out;
    logic valid, line_start, frame_start;
    logic [9:0] hcount, vcount;

    always #5 clk = ~clk;

    pixel_coord_gen #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .cos_a(cos_a), .sin_a(sin_a), .org_x(org_x), .org_y(org_y),
        .org2_x(org2_x), .org2_y(org2_y), .param_wr(param_wr),
        .xout(xout), .yout(yout), .x2out(x2out), .y2out(y2out),
        .valid(valid), .hcount(hcount), .vcount(vcount),
        .line_start(line_start), .frame_start(frame_start)
    );

    typedef struct {
        logic signed [15:0] x, y, x2, y2;
        int h, v;
        bit ls, fs;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int checks = 0;
    int errors = 0;

    // Bench reference model state
    int mh, mv, exp_hc, exp_vc;
    int s_cos, s_sin, s_ox, s_oy, s_o2x, s_o2y;
    int l_cos, l_sin, l_ox, l_oy, l_o2x, l_o2y;

    task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Closed-form coordinate o + n*a - m*b, reduced to 16 bits.
    function automatic logic signed [15:0] coord(int o, int a, int b, int n, int m);
        longint w;
        w = longint'(o) + longint'(n) * a - longint'(m) * b;
`ifdef PIXEL_COORD_SAT_EN
        if (w > 32767) w = 32767;
        if (w < -32768) w = -32768;
`endif
        return 16'(w);
    endfunction

    task automatic tick();
        exp_t e;
        bit pushed;
        pushed = 1'b0;
        if (reset) begin
            mh = 0; mv = 0; exp_hc = 0; exp_vc = 0;
            s_cos = 0; s_sin = 0; s_ox = 0; s_oy = 0; s_o2x = 0; s_o2y = 0;
            l_cos = 0; l_sin = 0; l_ox = 0; l_oy = 0; l_o2x = 0; l_o2y = 0;
            last = '{x: 16'sd0, y: 16'sd0, x2: 16'sd0, y2: 16'sd0, h: 0, v: 0, ls: 1'b0, fs: 1'b0};
            q.delete();
        end else begin
            if (param_wr) begin
                s_cos = cos_a; s_sin = sin_a; s_ox = org_x; s_oy = org_y;
                s_o2x = org2_x; s_o2y = org2_y;
            end
            if (ce) begin
                if (mh == 0 && mv == 0) begin
                    l_cos = s_cos; l_sin = s_sin; l_ox = s_ox; l_oy = s_oy;
                    l_o2x = s_o2x; l_o2y = s_o2y;
                end
                exp_hc = mh; exp_vc = mv;
                if (mh < HA && mv < VA) begin
                    e.x  = coord(l_ox, l_cos, l_sin, mh, mv);
                    e.y  = coord(l_oy, l_sin, -l_cos, mh, mv);
                    e.x2 = coord(l_o2x, l_cos, l_sin, mh, mv);
                    e.y2 = coord(l_o2y, l_sin, -l_cos, mh, mv);
                    e.h = mh; e.v = mv;
                    e.ls = (mh == 0); e.fs = (mh == 0 && mv == 0);
                    q.push_back(e);
                    pushed = 1'b1;
                end
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("valid", valid, pushed);
        chk("hcount", hcount, exp_hc);
        chk("vcount", vcount, exp_vc);
        if (pushed) begin
            if (q.size() == 0) begin
                chk("queue", 0, 1);
            end else begin
                e = q.pop_front();
                last = e;
            end
            chk("line_start", line_start, last.ls);
            chk("frame_start", frame_start, last.fs);
        end else begin
            chk("line_start_idle", line_start, 0);
            chk("frame_start_idle", frame_start, 0);
        end
        chk("xout", xout, last.x);
        chk("yout", yout, last.y);
        chk("x2out", x2out, last.x2);
        chk("y2out", y2out, last.y2);
    endtask

    task automatic run_to(int th, int tv);
        int n;
        n = 0;
        ce = 1'b1;
        while (!(mh == th && mv == tv)) begin
            tick();
            n++;
            if (n > 5000) begin
                checks++;
                errors++;
                $display("FAIL run_to timeout h=%0d v=%0d", th, tv);
                break;
            end
        end
    endtask

    task automatic set_params(int c, int s, int ox, int oy, int o2x, int o2y);
        cos_a = 16'(c); sin_a = 16'(s); org_x = 16'(ox); org_y = 16'(oy);
        org2_x = 16'(o2x); org2_y = 16'(o2y);
    endtask

    initial begin
        // Reset state
        reset = 1'b1; ce = 1'b0; param_wr = 1'b0;
        tick(); tick();
        chk("rst_x", xout, 0); chk("rst_y2", y2out, 0); chk("rst_valid", valid, 0);
        chk("rst_fs", frame_start, 0); chk("rst_hc", hcount, 0);
        reset = 1'b0;

        // Load step 256 and origins
        set_params(256, 0, -1000, 500, 0, 0);
        param_wr = 1'b1; tick(); param_wr = 1'b0;

        // First frame, first pixels
        ce = 1'b1; tick();
        chk("p0_x", xout, -1000); chk("p0_y", yout, 500);
        chk("p0_fs", frame_start, 1); chk("p0_hc", hcount, 0);
        tick();
        chk("p1_x", xout, -744);
        tick(); tick();

        // ce low for three cycles mid-line: hold, valid low, no skip
        ce = 1'b0;
        tick(); tick(); tick();
        chk("hold_valid", valid, 0); chk("hold_x", xout, -232);
        ce = 1'b1; tick();
        chk("resume_x", xout, 24); chk("resume_hc", hcount, 4);

        // Line 1 pixel 0
        run_to(0, 1); tick();
        chk("l1_x", xout, -1000); chk("l1_y", yout, 756);
        chk("l1_ls", line_start, 1); chk("l1_vc", vcount, 1);

        // Mid-frame write does not touch the current frame
        tick();
        set_params(512, 0, -1000, -28000, 0, 0);
        param_wr = 1'b1; tick(); param_wr = 1'b0;
        tick();
        chk("mid_keep_x", xout, -232);

        // Next frame uses the new step
        run_to(0, 0); tick(); tick();
        chk("nf_x", xout, -488); chk("nf_y", yout, -28000);

        // Rotated step on pair 2
        set_params(0, 100, -1000, -28000, 0, 0);
        param_wr = 1'b1; tick(); param_wr = 1'b0;
        run_to(0, 0);
        run_to(3, 2); tick();
        chk("rot_x2", x2out, -200); chk("rot_y2", y2out, 300);

        // Write on the frame-boundary cycle takes effect in that frame
        run_to(0, 0);
        set_params(1000, 0, 32000, 0, 0, 0);
        param_wr = 1'b1; tick(); param_wr = 1'b0;
        chk("bnd_x", xout, 32000);
        tick();
`ifdef PIXEL_COORD_SAT_EN
        chk("ovf_x", xout, 32767);
`else
        chk("ovf_x", xout, -32536);
`endif

        // Reset at v=100 dominates ce and param_wr
        run_to(0, 100); tick(); tick();
        set_params(77, 33, 5, 6, 7, 8);
        reset = 1'b1; param_wr = 1'b1; ce = 1'b1; tick();
        chk("r100_x", xout, 0); chk("r100_valid", valid, 0);
        chk("r100_vc", vcount, 0); chk("r100_ls", line_start, 0);
        reset = 1'b0; param_wr = 1'b0;
        tick();
        chk("post_valid", valid, 1); chk("post_fs", frame_start, 1);
        chk("post_x", xout, 0); chk("post_hc", hcount, 0);
        tick();
        chk("post_x1", xout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
